iter_alu: RTL

- Parametrised, handshaked, multi-cycle ALU.
- Successor to the team's 32-bit combinational AND/OR/ADD/SUB ALU.
- Adds registered results, status flags, signed compare, iterative multiply (shift-add) and unsigned divide/remainder (restoring).
- Sits in the execute stage. The pipeline stalls on in_ready/out_valid.

---
 rtl/iter_alu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - handshaked multi-cycle ALU with shift-add multiply and restoring divide
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             dbz
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] result_q;
  logic             cout_q, ovf_q, zero_q, dbz_q;

  logic             fin;
  logic [WIDTH-1:0] res_c;
  logic             cout_c, ovf_c, dbz_c;
  logic [WIDTH:0]   sum_c, diff_c, mul_c, div_sh, div_r;
  logic [WIDTH-1:0] div_q;
  logic             div_ge;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    fin     = 1'b0;
    res_c   = '0;
    cout_c  = 1'b0;
    ovf_c   = 1'b0;
    dbz_c   = 1'b0;

    sum_c  = {1'b0, in1} + {1'b0, in2};
    diff_c = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};

    // Multiply: a_q is the left-shifting multiplicand, b_q the right-shifting multiplier.
    mul_c = acc_q + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};

    // Divide: acc_q holds the partial remainder, a_q shifts dividend out and quotient in.
    div_sh = {acc_q[WIDTH-1:0], a_q[MSB]};
    div_ge = (div_sh >= {1'b0, b_q});
    div_r  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
    div_q  = {a_q[WIDTH-2:0], div_ge};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          case (op)
            OP_AND: begin
              res_c = in1 & in2;
              fin   = 1'b1;
            end
            OP_OR: begin
              res_c = in1 | in2;
              fin   = 1'b1;
            end
            OP_ADD: begin
              res_c  = sum_c[WIDTH-1:0];
              cout_c = sum_c[WIDTH];
              ovf_c  = (in1[MSB] == in2[MSB]) && (sum_c[MSB] != in1[MSB]);
              fin    = 1'b1;
            end
            OP_SUB: begin
              res_c  = diff_c[WIDTH-1:0];
              cout_c = diff_c[WIDTH];
              ovf_c  = (in1[MSB] != in2[MSB]) && (diff_c[MSB] != in1[MSB]);
              fin    = 1'b1;
            end
            OP_SLT: begin
              res_c = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
              fin   = 1'b1;
            end
            OP_MUL: begin
              acc_d   = '0;
              a_d     = in1;
              b_d     = in2;
              cnt_d   = CW'(WIDTH);
              state_d = S_BUSY;
            end
            default: begin
              // DIVU (110) / REMU (111); a zero divisor short-circuits to DONE.
              if (in2 == '0) begin
                dbz_c = 1'b1;
                res_c = op[0] ? in1 : {WIDTH{1'b1}};
                fin   = 1'b1;
              end else begin
                acc_d   = '0;
                a_d     = in1;
                b_d     = in2;
                cnt_d   = CW'(WIDTH);
                state_d = S_BUSY;
              end
            end
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_c;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          res_c = mul_c[WIDTH-1:0];
        end else begin
          acc_d = div_r;
          a_d   = div_q;
          res_c = op_q[0] ? div_r[WIDTH-1:0] : div_q;
        end
        fin = (cnt_q == CW'(1));
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      if (fin) begin
        result_q <= res_c;
        cout_q   <= cout_c;
        ovf_q    <= ovf_c;
        zero_q   <= (res_c == '0);
        dbz_q    <= dbz_c;
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign dbz       = dbz_q;

endmodule
